cache_controller: RTL and testbench
===================================

Name: cache_controller

Overview:
- 2-way set-associative, write-through, no-write-allocate cache between the MEM stage and sram_controller.
- Serves 32-bit word reads from on-chip storage on a hit.
- On a read miss, fetches a 64-bit line through sram_controller.
- Forwards every write to sram_controller and updates the cached copy on a write hit.
- ready_out is the pipeline freeze signal: the pipeline stalls while ready_out is low.

Parameters:
- SET_BITS, 6, set index width: 64 sets.
- TAG_BITS, 10, tag width.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- address_in  input  32  byte address from MEM stage, word-aligned. Bit 2 = word in line, [8:3] = set, [18:9] = tag.
- write_data_in  input  32  store data.
- r_en_in  input  1  load request, held until ready_out is sampled high.
- w_en_in  input  1  store request, held until ready_out is sampled high.
- read_data_out  output  32  load data, valid when ready_out=1 and r_en_in=1.
- ready_out  output  1  request complete; 0 = stall.
- sram_address_out  output  32  address to sram_controller.
- sram_write_data_out  output  32  store data to sram_controller.
- sram_r_en_out  output  1  line-fetch request.
- sram_w_en_out  output  1  word-write request.
- sram_read_data_in  input  64  fetched line, {word1, word0}.
- sram_ready_in  input  1  sram_controller completion pulse (one cycle).

Behaviour:
- Storage per set:
  - Per way: valid bit, 10-bit tag, 64-bit data.
  - One LRU bit per set, naming the way to replace next.
- Hit detection: hit_wN = valid_wN & (tag_wN == address_in[18:9]). Combinational, looked up in the set addressed by address_in[8:3].
- States: IDLE, READ_MISS, WRITE_THRU.
- IDLE behaviour:
  - No request: ready_out=1, read_data_out=0.
  - Read hit: ready_out=1 in the same cycle (zero-wait). read_data_out = selected word of the hitting way. At the clock edge, LRU = other way.
  - Read miss: ready_out=0. sram_r_en_out=1 combinationally. sram_address_out = {address_in[31:3], 3'b000}. Next state READ_MISS.
  - Write (hit or miss): ready_out=0. sram_w_en_out=1. sram_address_out = address_in. sram_write_data_out = write_data_in. Next state WRITE_THRU.
- READ_MISS:
  - sram_r_en_out and sram_address_out held.
  - On sram_ready_in=1, in the same cycle:
    - ready_out=1.
    - read_data_out = sram_read_data_in word selected by address_in[2].
  - At that clock edge:
    - Victim way = first invalid way (way0 before way1), else the LRU way.
    - Victim gets tag, data and valid=1; LRU = other way.
    - Next state IDLE.
- WRITE_THRU:
  - sram_w_en_out, address and data held.
  - On sram_ready_in=1: ready_out=1 in the same cycle.
  - At that clock edge:
    - On a write hit, the matching word of the hitting way is updated and LRU = other way.
    - On a miss, the cache is unchanged.
    - Next state IDLE.
- The sram enables drop in the cycle after sram_ready_in, because the FSM is back in IDLE.
- r_en_in and w_en_in both high: the write takes priority; the read is ignored.
- A request is never dropped mid-miss by the requester.
- Reset (asynchronous, any state):
  - State = IDLE.
  - All valid bits = 0; all LRU bits = 0.
  - Sram enables go to 0 immediately.
  - Tag and data arrays are not cleared.
- Outputs at reset: ready_out=1, read_data_out=0, sram_r_en_out=0, sram_w_en_out=0, sram_address_out=0, sram_write_data_out=0.

Optional Feature:
- CACHE_STATS_EN defined:
  - Adds outputs hit_count_out[31:0] and miss_count_out[31:0]. Both reset to 0.
  - Each counts read requests completed as hit or miss, incremented once at the completing clock edge.
  - Both wrap at 2^32.
- Undefined: the ports and counters are absent.

Test Plan:
- Reset, then read 0x0000 with the SRAM model preloaded word0=0x33441122, word1=0x77885566:
  - Miss: sram_r_en_out=1 with sram_address_out=0x0000.
  - Completes with read_data_out=0x33441122.
  - Re-read 0x0004 hits in 1 cycle with 0x77885566.
- Write 0x0004 <- 0xAABBCCDD after the line is cached:
  - sram_w_en_out=1 until sram_ready_in.
  - Following read 0x0004 hits with 0xAABBCCDD without an sram access.
- Write 0x0200 <- 0x12345678 (miss): SRAM is written, and a subsequent read 0x0200 misses (no allocate).
- Read 0x0000, 0x0200, 0x0000, then 0x0400 (same set 0, three tags):
  - 0x0400 evicts the 0x0200 line (LRU).
  - Read 0x0000 then hits; read 0x0200 misses.
- Assert rst while in READ_MISS:
  - Sram enables fall immediately and ready_out=1.
  - A read 0x0000 after reset misses again.
- r_en_in=1 and w_en_in=1 together at 0x0008 with data 0x0F0F0F0F: only sram_w_en_out asserts.
- With CACHE_STATS_EN: the scenario-1 sequence gives hit_count_out=1 and miss_count_out=1.

Source files
------------

// File: rtl/cache_controller.sv
// 2-way set-associative write-through, no-write-allocate cache; read hits complete in the same cycle.
// Optional CACHE_STATS_EN adds read hit/miss counters.
module cache_controller #(
  parameter int SET_BITS = 6,
  parameter int TAG_BITS = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] address_in,
  input  logic [31:0] write_data_in,
  input  logic        r_en_in,
  input  logic        w_en_in,
  output logic [31:0] read_data_out,
  output logic        ready_out,
  output logic [31:0] sram_address_out,
  output logic [31:0] sram_write_data_out,
  output logic        sram_r_en_out,
  output logic        sram_w_en_out,
  input  logic [63:0] sram_read_data_in,
  input  logic        sram_ready_in
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0] hit_count_out,
  output logic [31:0] miss_count_out
`endif
);

  localparam int SETS = 1 << SET_BITS;

  typedef enum logic [1:0] {IDLE, READ_MISS, WRITE_THRU} state_t;
  state_t state, state_next;

  logic [SETS-1:0]     valid0, valid1, lru;
  logic [TAG_BITS-1:0] tag0 [SETS];
  logic [TAG_BITS-1:0] tag1 [SETS];
  logic [63:0]         data0 [SETS];
  logic [63:0]         data1 [SETS];

  logic [SET_BITS-1:0] set_idx;
  logic [TAG_BITS-1:0] tag;
  logic                word_sel;
  logic                hit0, hit1, victim;
  logic                fill_en, wr_upd_en, lru_upd_en, lru_val;
  logic                stat_hit, stat_miss;

  assign set_idx  = address_in[3 +: SET_BITS];
  assign tag      = address_in[3 + SET_BITS +: TAG_BITS];
  assign word_sel = address_in[2];
  assign hit0     = valid0[set_idx] && (tag0[set_idx] == tag);
  assign hit1     = valid1[set_idx] && (tag1[set_idx] == tag);
  // Fill an empty way first (way0 before way1), otherwise the LRU way.
  assign victim   = !valid0[set_idx] ? 1'b0 : (!valid1[set_idx] ? 1'b1 : lru[set_idx]);

  function automatic logic [31:0] pick_word(input logic [63:0] line, input logic sel);
    return sel ? line[63:32] : line[31:0];
  endfunction

  always_comb begin
    state_next          = state;
    ready_out           = 1'b1;
    read_data_out       = '0;
    sram_address_out    = '0;
    sram_write_data_out = '0;
    sram_r_en_out       = 1'b0;
    sram_w_en_out       = 1'b0;
    fill_en             = 1'b0;
    wr_upd_en           = 1'b0;
    lru_upd_en          = 1'b0;
    lru_val             = 1'b0;
    stat_hit            = 1'b0;
    stat_miss           = 1'b0;
    // Outputs are forced to their idle values while reset is held.
    if (!rst) begin
      case (state)
        IDLE: begin
          if (w_en_in) begin
            ready_out           = 1'b0;
            sram_w_en_out       = 1'b1;
            sram_address_out    = address_in;
            sram_write_data_out = write_data_in;
            state_next          = WRITE_THRU;
          end else if (r_en_in) begin
            if (hit0 || hit1) begin
              read_data_out = pick_word(hit0 ? data0[set_idx] : data1[set_idx], word_sel);
              lru_upd_en    = 1'b1;
              lru_val       = hit0;
              stat_hit      = 1'b1;
            end else begin
              ready_out        = 1'b0;
              sram_r_en_out    = 1'b1;
              sram_address_out = {address_in[31:3], 3'b000};
              state_next       = READ_MISS;
            end
          end
        end
        READ_MISS: begin
          sram_r_en_out    = 1'b1;
          sram_address_out = {address_in[31:3], 3'b000};
          ready_out        = sram_ready_in;
          if (sram_ready_in) begin
            read_data_out = pick_word(sram_read_data_in, word_sel);
            fill_en       = 1'b1;
            lru_upd_en    = 1'b1;
            lru_val       = ~victim;
            stat_miss     = 1'b1;
            state_next    = IDLE;
          end
        end
        WRITE_THRU: begin
          sram_w_en_out       = 1'b1;
          sram_address_out    = address_in;
          sram_write_data_out = write_data_in;
          ready_out           = sram_ready_in;
          if (sram_ready_in) begin
            state_next = IDLE;
            if (hit0 || hit1) begin
              wr_upd_en  = 1'b1;
              lru_upd_en = 1'b1;
              lru_val    = hit0;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      valid0 <= '0;
      valid1 <= '0;
      lru    <= '0;
    end else begin
      state <= state_next;
      if (fill_en) begin
        if (victim) valid1[set_idx] <= 1'b1;
        else        valid0[set_idx] <= 1'b1;
      end
      if (lru_upd_en) lru[set_idx] <= lru_val;
    end
  end

  // Tag and data arrays carry no reset; the valid bits qualify them.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      if (victim) begin
        tag1[set_idx]  <= tag;
        data1[set_idx] <= sram_read_data_in;
      end else begin
        tag0[set_idx]  <= tag;
        data0[set_idx] <= sram_read_data_in;
      end
    end
    if (wr_upd_en) begin
      if (hit0) data0[set_idx][{word_sel, 5'b00000} +: 32] <= write_data_in;
      else      data1[set_idx][{word_sel, 5'b00000} +: 32] <= write_data_in;
    end
  end

`ifdef CACHE_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_count_out  <= '0;
      miss_count_out <= '0;
    end else begin
      if (stat_hit)  hit_count_out  <= hit_count_out + 32'd1;
      if (stat_miss) miss_count_out <= miss_count_out + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller with a fixed-latency SRAM model.
module tb_cache_controller;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] address_in = '0;
  logic [31:0] write_data_in = '0;
  logic        r_en_in = 1'b0;
  logic        w_en_in = 1'b0;
  logic [31:0] read_data_out;
  logic        ready_out;
  logic [31:0] sram_address_out;
  logic [31:0] sram_write_data_out;
  logic        sram_r_en_out;
  logic        sram_w_en_out;
  logic [63:0] sram_read_data_in;
  logic        sram_ready_in;
`ifdef CACHE_STATS_EN
  logic [31:0] hit_count_out;
  logic [31:0] miss_count_out;
`endif

  cache_controller dut (
    .clk(clk), .rst(rst), .address_in(address_in), .write_data_in(write_data_in),
    .r_en_in(r_en_in), .w_en_in(w_en_in), .read_data_out(read_data_out),
    .ready_out(ready_out), .sram_address_out(sram_address_out),
    .sram_write_data_out(sram_write_data_out), .sram_r_en_out(sram_r_en_out),
    .sram_w_en_out(sram_w_en_out), .sram_read_data_in(sram_read_data_in),
    .sram_ready_in(sram_ready_in)
`ifdef CACHE_STATS_EN
    , .hit_count_out(hit_count_out), .miss_count_out(miss_count_out)
`endif
  );

  always #5 clk = ~clk;

  // SRAM model: completes each request three cycles after the enable is first seen.
  logic [31:0] mem [0:511];
  logic [1:0]  cnt;
  int          acc;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt               <= '0;
      sram_ready_in     <= 1'b0;
      sram_read_data_in <= '0;
      for (int i = 0; i < 512; i++) mem[i] <= 32'd0;
      mem[0] <= 32'h33441122;
      mem[1] <= 32'h77885566;
    end else begin
      sram_ready_in <= 1'b0;
      if ((sram_r_en_out || sram_w_en_out) && !sram_ready_in) begin
        if (cnt == 2'd2) begin
          cnt           <= '0;
          sram_ready_in <= 1'b1;
          acc           <= acc + 1;
          if (sram_w_en_out) mem[sram_address_out[10:2]] <= sram_write_data_out;
          sram_read_data_in <= {mem[{sram_address_out[10:3], 1'b1}],
                                mem[{sram_address_out[10:3], 1'b0}]};
        end else begin
          cnt <= cnt + 2'd1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  logic        first_r, first_w, held;
  logic [31:0] first_addr, first_wdata;

  task automatic do_req(input logic [31:0] a, input logic [31:0] d, input logic r,
                        input logic w, output logic [31:0] rd, output int cyc);
    address_in    = a;
    write_data_in = d;
    r_en_in       = r;
    w_en_in       = w;
    cyc = 0;
    rd  = '0;
    held = 1'b1;
    forever begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        first_r     = sram_r_en_out;
        first_w     = sram_w_en_out;
        first_addr  = sram_address_out;
        first_wdata = sram_write_data_out;
      end else if (sram_r_en_out !== first_r || sram_w_en_out !== first_w) begin
        held = 1'b0;
      end
      if (ready_out) begin
        rd = read_data_out;
        break;
      end
      if (cyc >= 50) begin
        check("request_timeout", 32'd0, 32'd1);
        break;
      end
    end
    @(posedge clk);
    #1;
    r_en_in = 1'b0;
    w_en_in = 1'b0;
  endtask

  logic [31:0] rd;
  int          cyc, acc0;

  initial begin
    acc = 0;
    #12;
    check("rst_ready", ready_out, 1);
    check("rst_rdata", read_data_out, 0);
    check("rst_sram_r", sram_r_en_out, 0);
    check("rst_sram_w", sram_w_en_out, 0);
    check("rst_sram_addr", sram_address_out, 0);
    check("rst_sram_wdata", sram_write_data_out, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Cold read miss, then hit on the other word of the fetched line.
    do_req(32'h0000, 0, 1, 0, rd, cyc);
    check("miss0_sram_r", first_r, 1);
    check("miss0_addr", first_addr, 32'h0000);
    check("miss0_latency", cyc > 1, 1);
    check("miss0_data", rd, 32'h33441122);
    do_req(32'h0004, 0, 1, 0, rd, cyc);
    check("hit4_latency", cyc, 1);
    check("hit4_data", rd, 32'h77885566);
`ifdef CACHE_STATS_EN
    check("stats_hits", hit_count_out, 1);
    check("stats_misses", miss_count_out, 1);
`endif

    // Write hit goes through to SRAM and updates the cached word.
    acc0 = acc;
    do_req(32'h0004, 32'hAABBCCDD, 0, 1, rd, cyc);
    check("wr4_sram_w", first_w, 1);
    check("wr4_addr", first_addr, 32'h0004);
    check("wr4_wdata", first_wdata, 32'hAABBCCDD);
    check("wr4_held", held, 1);
    check("wr4_mem", mem[1], 32'hAABBCCDD);
    do_req(32'h0004, 0, 1, 0, rd, cyc);
    check("rd4_after_wr_latency", cyc, 1);
    check("rd4_after_wr_data", rd, 32'hAABBCCDD);
    check("rd4_sram_accesses", acc - acc0, 1);

    // Write miss: SRAM updated, nothing allocated.
    do_req(32'h0200, 32'h12345678, 0, 1, rd, cyc);
    check("wr200_mem", mem[128], 32'h12345678);
    do_req(32'h0200, 0, 1, 0, rd, cyc);
    check("rd200_miss", cyc > 1, 1);
    check("rd200_data", rd, 32'h12345678);

    // Three tags in set 0: 0x0400 evicts the least recently used 0x0200 line.
    do_req(32'h0000, 0, 1, 0, rd, cyc);
    check("lru_rd0_hit", cyc, 1);
    do_req(32'h0200, 0, 1, 0, rd, cyc);
    check("lru_rd200_hit", cyc, 1);
    do_req(32'h0000, 0, 1, 0, rd, cyc);
    check("lru_rd0_hit2", cyc, 1);
    do_req(32'h0400, 0, 1, 0, rd, cyc);
    check("lru_rd400_miss", cyc > 1, 1);
    do_req(32'h0000, 0, 1, 0, rd, cyc);
    check("lru_rd0_still_hit", cyc, 1);
    check("lru_rd0_data", rd, 32'h33441122);
    do_req(32'h0200, 0, 1, 0, rd, cyc);
    check("lru_rd200_evicted", cyc > 1, 1);

    // Reset in the middle of a read miss.
    address_in = 32'h0008;
    r_en_in    = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("mid_miss_sram_r", sram_r_en_out, 1);
    rst = 1'b1;
    #1;
    check("rst_mid_sram_r", sram_r_en_out, 0);
    check("rst_mid_sram_w", sram_w_en_out, 0);
    check("rst_mid_ready", ready_out, 1);
    r_en_in = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    do_req(32'h0000, 0, 1, 0, rd, cyc);
    check("post_rst_rd0_miss", cyc > 1, 1);
    check("post_rst_rd0_data", rd, 32'h33441122);

    // Read and write together: write wins.
    do_req(32'h0008, 32'h0F0F0F0F, 1, 1, rd, cyc);
    check("both_sram_r", first_r, 0);
    check("both_sram_w", first_w, 1);
    check("both_mem", mem[2], 32'h0F0F0F0F);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
